// File: rtl/mips_pkg.sv
// Shared MIPS definitions: supported opcodes, end-of-program marker and
// the program-loader state encoding.
package mips_pkg;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LWU   = 6'b100111;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_XORI  = 6'b001110;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_e;

   // True when the controller can decode this opcode.
   function automatic logic op_supported(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_ADDI, OP_ANDI, OP_BEQ, OP_BNE, OP_J, OP_JAL,
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LUI, OP_LW, OP_LWU, OP_ORI,
         OP_SB, OP_SH, OP_SW, OP_SLTI, OP_XORI: op_supported = 1'b1;
         default:                               op_supported = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte stream in from the UART receiver, word writes out to instruction memory.
interface instr_loader_if #(
   parameter int NB_BYTE  = 8,
   parameter int NB_INSTR = 32,
   parameter int NB_ADDR  = 8
);
   logic                i_rx_valid;
   logic [NB_BYTE-1:0]  i_rx_data;
   logic                o_imem_we;
   logic [NB_ADDR-1:0]  o_imem_addr;
   logic [NB_INSTR-1:0] o_imem_data;

   // Environment side: supplies bytes, observes memory writes.
   modport master (output i_rx_valid, i_rx_data,
                   input  o_imem_we, o_imem_addr, o_imem_data);
   // Loader side.
   modport slave  (input  i_rx_valid, i_rx_data,
                   output o_imem_we, o_imem_addr, o_imem_data);
endinterface

// File: rtl/instr_legal_check.sv
// Combinational legality check: supported opcode, or the HALT marker itself.
module instr_legal_check
   import mips_pkg::*;
#(
   parameter int              NB_INSTR  = 32,
   parameter logic [NB_INSTR-1:0] HALT_W = mips_pkg::HALT_WORD
) (
   input  logic [NB_INSTR-1:0] i_word,
   output logic                o_legal
);
   assign o_legal = op_supported(i_word[NB_INSTR-1 -: 6]) || (i_word == HALT_W);
endmodule

// File: rtl/instr_loader.sv
// Assembles big-endian UART bytes into words and writes them to instruction
// memory from address 0 until HALT or the memory is full.
module instr_loader
   import mips_pkg::*;
#(
   parameter int                  NB_BYTE   = 8,
   parameter int                  NB_INSTR  = 32,
   parameter int                  NB_ADDR   = 8,
   parameter logic [NB_INSTR-1:0] HALT_WORD = mips_pkg::HALT_WORD
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   instr_loader_if.slave    bus,
   output logic             o_busy,
   output logic             o_done,
   output logic [NB_ADDR:0] o_word_count,
   output logic             o_err_opcode,
   output logic             o_err_overflow
);
   localparam int NB_SHIFT = NB_INSTR - NB_BYTE;

   loader_state_e       state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [NB_SHIFT-1:0] shift_q, shift_d;
   logic [NB_ADDR-1:0]  addr_q, addr_d;
   logic [NB_INSTR-1:0] data_q, data_d;
   logic                we_q, we_d;
   logic [NB_ADDR:0]    count_q, count_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_op_q, err_op_d;
   logic                err_ov_q, err_ov_d;
   logic                legal;

   instr_legal_check #(.NB_INSTR(NB_INSTR), .HALT_W(HALT_WORD)) u_legal (
      .i_word  (data_q),
      .o_legal (legal)
   );

   // Next-state, byte assembly and write sequencing.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      addr_d   = addr_q;
      data_d   = data_q;
      we_d     = 1'b0;
      count_d  = count_q;
      busy_d   = busy_q;
      done_d   = done_q;
      err_op_d = err_op_q;
      err_ov_d = err_ov_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // Bytes are ignored here, even one coincident with i_start.
            if (i_start) begin
               state_d  = ST_RECV;
               cnt_d    = '0;
               shift_d  = '0;
               addr_d   = '0;
               count_d  = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               err_op_d = 1'b0;
               err_ov_d = 1'b0;
            end
         end
         ST_RECV: begin
            if (bus.i_rx_valid) begin
               shift_d = {shift_q[NB_SHIFT-NB_BYTE-1:0], bus.i_rx_data};
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  data_d  = {shift_q, bus.i_rx_data};
                  we_d    = 1'b1;
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            count_d = count_q + {{NB_ADDR{1'b0}}, 1'b1};
            if (!legal) err_op_d = 1'b1;
            // A byte here is the first byte of the next word.
            if (bus.i_rx_valid) begin
               shift_d = {shift_q[NB_SHIFT-NB_BYTE-1:0], bus.i_rx_data};
               cnt_d   = cnt_q + 2'd1;
            end
            if (data_q == HALT_WORD) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (&addr_q) begin
               state_d  = ST_DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               err_ov_d = 1'b1;
            end else begin
               addr_d  = addr_q + {{(NB_ADDR-1){1'b0}}, 1'b1};
               state_d = ST_RECV;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         we_q     <= 1'b0;
         count_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_op_q <= 1'b0;
         err_ov_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         we_q     <= we_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_op_q <= err_op_d;
         err_ov_q <= err_ov_d;
      end
   end

   assign bus.o_imem_we   = we_q;
   assign bus.o_imem_addr = addr_q;
   assign bus.o_imem_data = data_q;
   assign o_busy          = busy_q;
   assign o_done          = done_q;
   assign o_word_count    = count_q;
   assign o_err_opcode    = err_op_q;
   assign o_err_overflow  = err_ov_q;

endmodule
